// File: rtl/cpc_mem_pkg.sv
// Shared types for the CPC memory mapper: address field widths, boot FSM states
// and the CPC RAM banking table.
package cpc_mem_pkg;

  localparam int PAGE_W   = 7;
  localparam int OFFSET_W = 14;
  localparam int SRAM_AW  = PAGE_W + OFFSET_W;

  typedef enum logic [2:0] {
    BOOT_IDLE,
    BOOT_B0,
    BOOT_B1,
    BOOT_B2,
    BOOT_B3,
    BOOT_ACK,
    BOOT_DONE
  } boot_state_t;

  // Maps a 16 KB CPU quarter to a logical RAM bank (RAM_0..RAM_7) for a given cfg.
  function automatic logic [2:0] cpc_ram_bank(input logic [2:0] cfg, input logic [1:0] q);
    logic [2:0] k;
    k = {1'b0, q};
    case (cfg)
      3'd0: k = {1'b0, q};
      3'd1: if (q == 2'd3) k = 3'd7;
      3'd2: k = {1'b1, q};
      3'd3: begin
        if (q == 2'd1) k = 3'd3;
        if (q == 2'd3) k = 3'd7;
      end
      default: if (q == 2'd1) k = cfg;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/cpc_boot_writer.sv
// Boot loader: accepts 32-bit host words and writes them MSB-first into SRAM
// starting at BOOT_BASE until BOOT_BYTES bytes have been written.
module cpc_boot_writer
  import cpc_mem_pkg::*;
#(
  parameter logic [SRAM_AW-1:0] BOOT_BASE  = 21'h100000,
  parameter logic [SRAM_AW-1:0] BOOT_BYTES = 21'h14000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        host_bootdata,
  input  logic               host_bootdata_req,
  output logic               host_bootdata_ack,
  output logic               boot_we_n,
  output logic [SRAM_AW-1:0] boot_addr,
  output logic [7:0]         boot_dout,
  output boot_state_t        state
);

  // Handshake: req is a level; a word is taken in IDLE only if req has been
  // observed low since the previous ACK, and ack pulses for exactly one cycle.
  boot_state_t        state_d;
  logic [SRAM_AW-1:0] count_q;
  logic [31:0]        word_q;
  logic               armed_q;
  logic               load;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= BOOT_IDLE;
      count_q <= '0;
      word_q  <= '0;
      armed_q <= 1'b1;
    end else begin
      state <= state_d;
      if (load) word_q <= host_bootdata;
      if (!boot_we_n) count_q <= count_q + 1'b1;
      if (!host_bootdata_req) armed_q <= 1'b1;
      else if (state == BOOT_ACK) armed_q <= 1'b0;
    end
  end

  always_comb begin
    state_d           = state;
    load              = 1'b0;
    host_bootdata_ack = 1'b0;
    boot_we_n         = 1'b1;
    boot_dout         = 8'h00;
    boot_addr         = '0;
    case (state)
      BOOT_IDLE: begin
        if (host_bootdata_req && armed_q) begin
          load    = 1'b1;
          state_d = BOOT_B0;
        end
      end
      BOOT_B0: begin
        boot_we_n = 1'b0;
        boot_dout = word_q[31:24];
        state_d   = BOOT_B1;
      end
      BOOT_B1: begin
        boot_we_n = 1'b0;
        boot_dout = word_q[23:16];
        state_d   = BOOT_B2;
      end
      BOOT_B2: begin
        boot_we_n = 1'b0;
        boot_dout = word_q[15:8];
        state_d   = BOOT_B3;
      end
      BOOT_B3: begin
        boot_we_n = 1'b0;
        boot_dout = word_q[7:0];
        state_d   = BOOT_ACK;
      end
      BOOT_ACK: begin
        host_bootdata_ack = 1'b1;
        state_d = (count_q == BOOT_BYTES) ? BOOT_DONE : BOOT_IDLE;
      end
      BOOT_DONE: state_d = BOOT_DONE;
      default:   state_d = BOOT_IDLE;
    endcase
    if (!boot_we_n) boot_addr = BOOT_BASE + count_q;
  end

endmodule

// File: rtl/cpc_memory_mapper.sv
// Amstrad CPC memory mapper with upper-ROM slot selection and integrated boot loader.
// Define CPC_RAM_EXPANSION_EN to honour the exp bits (up to 576 KB); otherwise 128 KB.
module cpc_memory_mapper
  import cpc_mem_pkg::*;
#(
  parameter int                 ROM_BASE_PAGE  = 64,
  parameter int                 LOWER_ROM_PAGE = 80,
  parameter logic [15:0]        ROM_SLOT_MASK  = 16'h0081,
  parameter logic [SRAM_AW-1:0] BOOT_BASE      = 21'h100000,
  parameter logic [SRAM_AW-1:0] BOOT_BYTES     = 21'h14000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [15:0]        cpu_addr,
  input  logic               iorq_n,
  input  logic               rd_n,
  input  logic               wr_n,
  input  logic [7:0]         data_from_cpu,
  input  logic [15:0]        vram_addr,
  input  logic               cpu_n,
  input  logic               romen_n,
  input  logic               ramrd_n,
  input  logic               ras_n,
  input  logic               cas_n,
  input  logic               mwe_n,
  input  logic               ready,
  output logic [7:0]         data_to_cpu,
  output logic               memory_oe_n,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [7:0]         sram_dout,
  input  logic [7:0]         sram_din,
  output logic               sram_we_n,
  input  logic [31:0]        host_bootdata,
  input  logic               host_bootdata_req,
  output logic               host_bootdata_ack,
  output logic               rom_initialised
);

  logic [2:0]          cfg_q;
  logic [2:0]          exp_sel;
  logic [7:0]          rom_bank_q;
  logic [3:0]          eff_slot;
  logic [2:0]          ram_k;
  logic [PAGE_W-1:0]   page_d;
  logic [OFFSET_W-1:0] offset_d;
  logic                is_rom_d;
  logic [SRAM_AW-1:0]  addr_q;
  logic                rom_q;
  logic [7:0]          rd_latch;
  logic                cfg_wr;
  logic                unused_rd;
  boot_state_t         boot_state;
  logic                boot_we_n;
  logic [SRAM_AW-1:0]  boot_addr;
  logic [7:0]          boot_dout;

  assign unused_rd = rd_n;
  assign cfg_wr    = !iorq_n && !wr_n && !cpu_addr[15] && (data_from_cpu[7:6] == 2'b11);

  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_q      <= 3'd0;
      rom_bank_q <= 8'h00;
    end else begin
      if (cfg_wr) cfg_q <= data_from_cpu[2:0];
      if (!iorq_n && !wr_n && cpu_addr[15:8] == 8'hDF) rom_bank_q <= data_from_cpu;
    end
  end

`ifdef CPC_RAM_EXPANSION_EN
  always_ff @(posedge clk) begin
    if (reset) exp_sel <= 3'd0;
    else if (cfg_wr) exp_sel <= data_from_cpu[5:3];
  end
`else
  assign exp_sel = 3'd0;
`endif

  // Unpopulated or out-of-range ROM selections fall back to slot 0 (BASIC).
  assign eff_slot = (rom_bank_q < 8'd16 && ROM_SLOT_MASK[rom_bank_q[3:0]]) ? rom_bank_q[3:0] : 4'd0;
  assign ram_k    = cpc_ram_bank(cfg_q, cpu_addr[15:14]);

  always_comb begin
    page_d   = PAGE_W'(ram_k[1:0]);
    offset_d = cpu_addr[OFFSET_W-1:0];
    is_rom_d = 1'b0;
    if (cpu_n) begin
      page_d   = PAGE_W'(vram_addr[15:14]);
      offset_d = vram_addr[OFFSET_W-1:0];
    end else if (!romen_n && cpu_addr[15:14] == 2'd0) begin
      page_d   = PAGE_W'(LOWER_ROM_PAGE);
      is_rom_d = 1'b1;
    end else if (!romen_n && cpu_addr[15:14] == 2'd3) begin
      page_d   = PAGE_W'(ROM_BASE_PAGE) + PAGE_W'(eff_slot);
      is_rom_d = 1'b1;
    end else if (ram_k[2]) begin
      page_d = (PAGE_W'(exp_sel) << 2) + PAGE_W'(4) + PAGE_W'(ram_k[1:0]);
    end
  end

  // Address and ROM flag are captured together so write protection follows the access.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q   <= '0;
      rom_q    <= 1'b0;
      rd_latch <= 8'hFF;
    end else begin
      if (rom_initialised && !ras_n) begin
        addr_q <= {page_d, offset_d};
        rom_q  <= is_rom_d;
      end
      if (ready) rd_latch <= sram_din;
    end
  end

  cpc_boot_writer #(
    .BOOT_BASE (BOOT_BASE),
    .BOOT_BYTES(BOOT_BYTES)
  ) u_boot (
    .clk              (clk),
    .reset            (reset),
    .host_bootdata    (host_bootdata),
    .host_bootdata_req(host_bootdata_req),
    .host_bootdata_ack(host_bootdata_ack),
    .boot_we_n        (boot_we_n),
    .boot_addr        (boot_addr),
    .boot_dout        (boot_dout),
    .state            (boot_state)
  );

  assign rom_initialised = (boot_state == BOOT_DONE);
  assign sram_addr   = rom_initialised ? addr_q : boot_addr;
  assign sram_dout   = rom_initialised ? data_from_cpu : boot_dout;
  assign sram_we_n   = rom_initialised ? (ras_n | cas_n | mwe_n | rom_q) : boot_we_n;
  assign memory_oe_n = ramrd_n & romen_n;
  assign data_to_cpu = memory_oe_n ? 8'hFF : rd_latch;

endmodule

// File: tb/tb_cpc_memory_mapper.sv
// Self-checking bench for cpc_memory_mapper: boot loader, RAM/ROM paging,
// write protection, video path and read latch.
module tb_cpc_memory_mapper;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] cpu_addr = 16'h0000;
  logic        iorq_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
  logic [7:0]  data_from_cpu = 8'h00;
  logic [15:0] vram_addr = 16'h0000;
  logic        cpu_n = 1'b1, romen_n = 1'b1, ramrd_n = 1'b1;
  logic        ras_n = 1'b1, cas_n = 1'b1, mwe_n = 1'b1, ready = 1'b0;
  logic [7:0]  data_to_cpu;
  logic        memory_oe_n;
  logic [20:0] sram_addr;
  logic [7:0]  sram_dout;
  logic [7:0]  sram_din = 8'h00;
  logic        sram_we_n;
  logic [31:0] host_bootdata = 32'h0;
  logic        host_bootdata_req = 1'b0;
  logic        host_bootdata_ack;
  logic        rom_initialised;

  logic [28:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  cpc_memory_mapper #(
    .ROM_BASE_PAGE (64),
    .LOWER_ROM_PAGE(80),
    .ROM_SLOT_MASK (16'h0081),
    .BOOT_BASE     (21'h100000),
    .BOOT_BYTES    (21'd8)
  ) dut (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .iorq_n(iorq_n), .rd_n(rd_n),
    .wr_n(wr_n), .data_from_cpu(data_from_cpu), .vram_addr(vram_addr),
    .cpu_n(cpu_n), .romen_n(romen_n), .ramrd_n(ramrd_n), .ras_n(ras_n),
    .cas_n(cas_n), .mwe_n(mwe_n), .ready(ready), .data_to_cpu(data_to_cpu),
    .memory_oe_n(memory_oe_n), .sram_addr(sram_addr), .sram_dout(sram_dout),
    .sram_din(sram_din), .sram_we_n(sram_we_n), .host_bootdata(host_bootdata),
    .host_bootdata_req(host_bootdata_req), .host_bootdata_ack(host_bootdata_ack),
    .rom_initialised(rom_initialised)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic io_write(input logic [15:0] a, input logic [7:0] d);
    cpu_addr = a; data_from_cpu = d; iorq_n = 1'b0; wr_n = 1'b0;
    @(posedge clk); #1;
    iorq_n = 1'b1; wr_n = 1'b1;
  endtask

  task automatic mem_cycle(input logic [15:0] a, input logic cpun, input logic romen);
    cpu_addr = a; cpu_n = cpun; romen_n = romen; ras_n = 1'b0;
    @(posedge clk); #1;
    ras_n = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec += 6;
    if (host_bootdata_ack !== 1'b0) begin n_err++; $display("FAIL reset_ack got %b want 0", host_bootdata_ack); end
    if (rom_initialised !== 1'b0) begin n_err++; $display("FAIL reset_rominit got %b want 0", rom_initialised); end
    if (sram_we_n !== 1'b1) begin n_err++; $display("FAIL reset_we got %b want 1", sram_we_n); end
    if (sram_addr !== 21'h0) begin n_err++; $display("FAIL reset_addr got %h want 000000", sram_addr); end
    if (data_to_cpu !== 8'hFF) begin n_err++; $display("FAIL reset_data got %h want ff", data_to_cpu); end
    if (memory_oe_n !== 1'b1) begin n_err++; $display("FAIL reset_oe got %b want 1", memory_oe_n); end
    ramrd_n = 1'b0;
    @(negedge clk);
    n_vec++;
    if (data_to_cpu !== 8'hFF) begin n_err++; $display("FAIL reset_latch got %h want ff", data_to_cpu); end
    ramrd_n = 1'b1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_boot_abort();
    int writes = 0;
    int guard = 0;
    int bad = 0;
    logic [28:0] want;
    exp_q.push_back({21'h100000, 8'hAA});
    exp_q.push_back({21'h100001, 8'hBB});
    exp_q.push_back({21'h100002, 8'hCC});
    host_bootdata = 32'hAABBCCDD;
    host_bootdata_req = 1'b1;
    while (writes < 3 && guard < 20) begin
      @(negedge clk);
      guard++;
      if (sram_we_n === 1'b0) begin
        writes++;
        want = exp_q.pop_front();
        n_vec++;
        if ({sram_addr, sram_dout} !== want)
          begin n_err++; $display("FAIL abort_write got %h/%h want %h/%h", sram_addr, sram_dout, want[28:8], want[7:0]); end
      end
    end
    n_vec++;
    if (writes != 3) begin n_err++; $display("FAIL abort_timeout got %0d writes want 3", writes); end
    exp_q.delete();
    // Still inside B2 here: reset lands on the next edge.
    reset = 1'b1;
    host_bootdata_req = 1'b0;
    @(negedge clk);
    n_vec += 3;
    if (sram_we_n !== 1'b1) begin n_err++; $display("FAIL abort_we got %b want 1", sram_we_n); end
    if (host_bootdata_ack !== 1'b0) begin n_err++; $display("FAIL abort_ack got %b want 0", host_bootdata_ack); end
    if (rom_initialised !== 1'b0) begin n_err++; $display("FAIL abort_rominit got %b want 0", rom_initialised); end
    reset = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (host_bootdata_ack !== 1'b0 || sram_we_n !== 1'b1 || rom_initialised !== 1'b0) bad++;
    end
    n_vec++;
    if (bad != 0) begin n_err++; $display("FAIL abort_quiet got %0d active cycles want 0", bad); end
  endtask

  task automatic test_boot();
    int acks = 0;
    int guard = 0;
    bit pending = 1'b0;
    logic [28:0] want;
    logic [7:0] bytes_v[8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    for (int i = 0; i < 8; i++) exp_q.push_back({21'h100000 + 21'(i), bytes_v[i]});
    host_bootdata = 32'h11223344;
    host_bootdata_req = 1'b1;
    while (acks < 2 && guard < 60) begin
      @(negedge clk);
      guard++;
      if (pending) begin
        host_bootdata = 32'h55667788;
        host_bootdata_req = 1'b1;
        pending = 1'b0;
      end
      if (sram_we_n === 1'b0) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL boot_extra_write got %h/%h want none", sram_addr, sram_dout);
        end else begin
          want = exp_q.pop_front();
          if ({sram_addr, sram_dout} !== want)
            begin n_err++; $display("FAIL boot_write got %h/%h want %h/%h", sram_addr, sram_dout, want[28:8], want[7:0]); end
        end
      end
      if (host_bootdata_ack === 1'b1) begin
        acks++;
        host_bootdata_req = 1'b0;
        n_vec++;
        if (rom_initialised !== 1'b0) begin n_err++; $display("FAIL boot_early_init got %b want 0 at ack %0d", rom_initialised, acks); end
        if (acks == 1) pending = 1'b1;
      end
    end
    @(negedge clk);
    n_vec += 3;
    if (acks != 2) begin n_err++; $display("FAIL boot_acks got %0d want 2", acks); end
    if (exp_q.size() != 0) begin n_err++; $display("FAIL boot_missing got %0d pending want 0", exp_q.size()); end
    if (rom_initialised !== 1'b1) begin n_err++; $display("FAIL boot_init got %b want 1", rom_initialised); end
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_ram_map();
    logic [7:0]  cfgv[6] = '{8'hC2, 8'hC2, 8'hC1, 8'hC3, 8'hC0, 8'hCC};
    logic [15:0] av[6]   = '{16'hC000, 16'h0123, 16'hC000, 16'h4000, 16'h8123, 16'h4000};
    logic [20:0] ev[6];
    logic [28:0] want;
    ev[0] = 21'h01C000; ev[1] = 21'h010123; ev[2] = 21'h01C000;
    ev[3] = 21'h00C000; ev[4] = 21'h008123;
`ifdef CPC_RAM_EXPANSION_EN
    ev[5] = 21'h020000;
`else
    ev[5] = 21'h010000;
`endif
    for (int i = 0; i < 6; i++) begin
      io_write(16'h7F00, cfgv[i]);
      exp_q.push_back({ev[i], 8'h00});
      mem_cycle(av[i], 1'b0, 1'b1);
      @(negedge clk);
      want = exp_q.pop_front();
      n_vec++;
      if (sram_addr !== want[28:8])
        begin n_err++; $display("FAIL ram_map[%0d] cfg %h addr %h got %h want %h", i, cfgv[i], av[i], sram_addr, want[28:8]); end
    end
    io_write(16'h7F00, 8'hC0);
  endtask

  task automatic test_rom_map();
    logic [7:0]  bankv[4] = '{8'h07, 8'h05, 8'h20, 8'h00};
    logic [15:0] av[4]    = '{16'hE000, 16'hE000, 16'hC010, 16'h0100};
    logic [20:0] ev[4]    = '{21'h11E000, 21'h102000, 21'h100010, 21'h140100};
    logic [28:0] want;
    for (int i = 0; i < 4; i++) begin
      io_write(16'hDF00, bankv[i]);
      exp_q.push_back({ev[i], 8'h00});
      mem_cycle(av[i], 1'b0, 1'b0);
      @(negedge clk);
      want = exp_q.pop_front();
      n_vec++;
      if (sram_addr !== want[28:8])
        begin n_err++; $display("FAIL rom_map[%0d] bank %h addr %h got %h want %h", i, bankv[i], av[i], sram_addr, want[28:8]); end
    end
    romen_n = 1'b1;
  endtask

  task automatic test_write_protect();
    // Lower ROM write must be blocked.
    cpu_addr = 16'h0100; cpu_n = 1'b0; romen_n = 1'b0; ras_n = 1'b0; data_from_cpu = 8'h3C;
    @(posedge clk); #1;
    cas_n = 1'b0; mwe_n = 1'b0; wr_n = 1'b0;
    @(negedge clk);
    n_vec++;
    if (sram_we_n !== 1'b1) begin n_err++; $display("FAIL rom_write_we got %b want 1", sram_we_n); end
    ras_n = 1'b1; cas_n = 1'b1; mwe_n = 1'b1; wr_n = 1'b1; romen_n = 1'b1;
    @(posedge clk); #1;
    // Same address as RAM: write goes through.
    ras_n = 1'b0;
    @(posedge clk); #1;
    cas_n = 1'b0; mwe_n = 1'b0; wr_n = 1'b0;
    @(negedge clk);
    n_vec += 3;
    if (sram_we_n !== 1'b0) begin n_err++; $display("FAIL ram_write_we got %b want 0", sram_we_n); end
    if (sram_dout !== 8'h3C) begin n_err++; $display("FAIL ram_write_data got %h want 3c", sram_dout); end
    if (sram_addr !== 21'h000100) begin n_err++; $display("FAIL ram_write_addr got %h want 000100", sram_addr); end
    ras_n = 1'b1; cas_n = 1'b1; mwe_n = 1'b1; wr_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_coincident_write();
    io_write(16'hDF00, 8'h05);
    // Select ROM 7 on the same edge as a ROM access: the access still sees slot 0.
    cpu_addr = 16'hDF00; data_from_cpu = 8'h07; iorq_n = 1'b0; wr_n = 1'b0;
    cpu_n = 1'b0; romen_n = 1'b0; ras_n = 1'b0;
    @(posedge clk); #1;
    iorq_n = 1'b1; wr_n = 1'b1; ras_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (sram_addr !== 21'h101F00) begin n_err++; $display("FAIL coincident_old got %h want 101f00", sram_addr); end
    mem_cycle(16'hDF00, 1'b0, 1'b0);
    @(negedge clk);
    n_vec++;
    if (sram_addr !== 21'h11DF00) begin n_err++; $display("FAIL coincident_new got %h want 11df00", sram_addr); end
    romen_n = 1'b1;
  endtask

  task automatic test_video();
    io_write(16'h7F00, 8'hC2);
    vram_addr = 16'hC123;
    mem_cycle(16'h4000, 1'b1, 1'b1);
    @(negedge clk);
    n_vec++;
    if (sram_addr !== 21'h00C123) begin n_err++; $display("FAIL video_addr got %h want 00c123", sram_addr); end
  endtask

  task automatic test_read_latch();
    sram_din = 8'h5A; ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0; sram_din = 8'h00; ramrd_n = 1'b0;
    @(negedge clk);
    n_vec += 2;
    if (data_to_cpu !== 8'h5A) begin n_err++; $display("FAIL latch_ram got %h want 5a", data_to_cpu); end
    if (memory_oe_n !== 1'b0) begin n_err++; $display("FAIL latch_oe got %b want 0", memory_oe_n); end
    ramrd_n = 1'b1;
    @(negedge clk);
    n_vec += 2;
    if (data_to_cpu !== 8'hFF) begin n_err++; $display("FAIL latch_idle got %h want ff", data_to_cpu); end
    if (memory_oe_n !== 1'b1) begin n_err++; $display("FAIL latch_idle_oe got %b want 1", memory_oe_n); end
    romen_n = 1'b0;
    @(negedge clk);
    n_vec++;
    if (data_to_cpu !== 8'h5A) begin n_err++; $display("FAIL latch_rom got %h want 5a", data_to_cpu); end
    romen_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_boot_abort();
    test_boot();
    test_ram_map();
    test_rom_map();
    test_write_protect();
    test_coincident_write();
    test_video();
    test_read_latch();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
